image_blitter: RTL and testbench
================================

Name: image_blitter

Overview:
- Parametrised successor to the fixed-size background loader.
- Streams an IMG_W x IMG_H image from a synchronous ROM/BRAM (MIF-initialised) to the vga_adapter pixel interface (oX/oY/oColor/oPlot).
- Supports a runtime origin, screen-edge clipping, solid-fill (erase) mode and a configurable ROM read latency, so no coordinate fudge offsets are needed.
- Instantiated inside project-level control, one per sprite/screen source, muxed onto the adapter.

Parameters:
- SCREEN_W, 160, screen width in pixels; clip bound for X.
- SCREEN_H, 120, screen height in pixels; clip bound for Y.
- IMG_W, 160, image width in pixels, 1..SCREEN_W.
- IMG_H, 120, image height in pixels, 1..SCREEN_H.
- X_W, 8, width of X coordinates.
- Y_W, 7, width of Y coordinates.
- COLOR_W, 3, colour bits per pixel.
- ADDR_W, 15, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- ROM_LATENCY, 1, cycles from oRomAddr to valid iRomData, 1..4.

Ports:
- iClock  in  1  system clock (CLOCK_50).
- iReset  in  1  asynchronous, active-high reset.
- iStart  in  1  single-cycle start request; sampled only in IDLE.
- iFill  in  1  latched at start; 1 = draw iFillColor instead of ROM data.
- iFillColor  in  COLOR_W  fill colour; latched at start.
- iX0  in  X_W  image origin X; latched at start.
- iY0  in  Y_W  image origin Y; latched at start.
- oRomAddr  out  ADDR_W  ROM read address.
- iRomData  in  COLOR_W  ROM read data, valid ROM_LATENCY cycles after the address.
- oX  out  X_W  pixel X.
- oY  out  Y_W  pixel Y.
- oColor  out  COLOR_W  pixel colour.
- oPlot  out  1  write strobe to the adapter.
- oBusy  out  1  high from the cycle after start acceptance until the cycle oDone pulses.
- oDone  out  1  one-cycle completion pulse.

Behaviour:
- Reset:
  - All outputs are 0.
  - State goes to IDLE; counters and delay line clear.
  - Reset asserted mid-run aborts the run immediately; no oDone is produced.
- States:
  - IDLE: on iStart, latch iX0, iY0, iFill and iFillColor, clear col, row and addr, then go to RUN.
  - RUN: oRomAddr = addr. In RUN cycle k (k = 0..N-1, N = IMG_W*IMG_H), issue pixel k:
    - addr increments by 1 each cycle.
    - col increments and wraps to 0 at IMG_W-1; row increments on that wrap.
    - After issuing k = N-1, go to DRAIN.
  - DRAIN: wait ROM_LATENCY cycles, then go to DONE.
  - DONE: oDone = 1 for one cycle, oBusy = 0, return to IDLE.
- Output timing:
  - The tag (sx = iX0 + col, sy = iY0 + row, valid) travels through a ROM_LATENCY-stage delay line.
  - Pixel k appears on oX/oY/oColor/oPlot in cycle k + ROM_LATENCY, counted from the first RUN cycle.
  - oDone is high in cycle N + ROM_LATENCY.
- Arithmetic and clipping:
  - sx is computed at X_W+1 bits and sy at Y_W+1 bits.
  - oPlot = valid && sx < SCREEN_W && sy < SCREEN_H.
  - oX/oY are the truncated sums.
  - Clipped pixels still consume their cycle and address, so timing is independent of the origin.
- Colour: oColor = latched fill colour when iFill, else iRomData. In fill mode oRomAddr still sequences normally.
- oX, oY and oColor are registered and hold their last value when oPlot = 0.
- Boundaries:
  - iStart while busy or in DONE is ignored.
  - iStart in the same cycle as iReset is ignored.
  - Back-to-back runs: iStart in the cycle after oDone is accepted.
  - IMG_W = 1 and IMG_H = 1 are both legal; N = 1 gives oDone in cycle 1 + ROM_LATENCY.

Optional Feature:
- Macro: BLIT_TRANSPARENCY_EN.
- Defined:
  - Adds input iKeyColor (COLOR_W), latched at start.
  - In ROM mode, a pixel with iRomData == key has oPlot forced to 0, so the background shows through.
  - Fill mode is unaffected.
- Undefined: the port is absent and every in-bounds pixel plots.

Decomposition:
- Package blit_pkg holds the state encoding (IDLE, RUN, DRAIN, DONE) and the default screen constants (160, 120, COLOR_W = 3).
- One sub-module, blit_delay_line: a parametrised ROM_LATENCY-deep shift register carrying {valid, sx, sy}, cleared by iReset.

Test Plan:
- Origin (0,0), IMG 4x3, latency 1, ROM data = addr[2:0], iStart -> 12 plots.
  - Pixel k at (k%4, k/4) with colour k[2:0].
  - oRomAddr 0..11; oDone in cycle 13 after start acceptance.
- Clipping: origin (158,118), IMG 4x3 -> exactly 4 plots at (158,118), (159,118), (158,119) and (159,119); oDone timing unchanged (cycle 13).
- Fill mode: iFill = 1, iFillColor = 3'b101, 4x3 at (10,20) -> 12 plots, all colour 5, covering x 10..13 and y 20..22.
- Latency 3: same 4x3 run -> first plot 3 cycles after address 0, colours still aligned; oDone in cycle 15.
- Reset mid-run after 5 pixels -> all outputs 0, no oDone. A new iStart then produces a full 12-pixel run from address 0.
- Start while busy: iStart pulsed mid-run -> ignored, exactly 12 plots, one oDone. With BLIT_TRANSPARENCY_EN and key 3'b000, pixels 0 and 8 are not plotted.

Source files
------------

// File: rtl/blit_pkg.sv
// rtl/blit_pkg.sv - shared state encoding and default screen constants for image_blitter
package blit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } blit_state_t;

  localparam int BLIT_SCREEN_W = 160;
  localparam int BLIT_SCREEN_H = 120;
  localparam int BLIT_COLOR_W  = 3;

endpackage

// File: rtl/image_blitter_if.sv
// rtl/image_blitter_if.sv - ROM read port and vga_adapter pixel bus of one image_blitter
interface image_blitter_if import blit_pkg::*; #(
  parameter int ADDR_W  = 15,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = BLIT_COLOR_W
) ();

  logic [ADDR_W-1:0]  oRomAddr;
  logic [COLOR_W-1:0] iRomData;
  logic [X_W-1:0]     oX;
  logic [Y_W-1:0]     oY;
  logic [COLOR_W-1:0] oColor;
  logic               oPlot;

  modport master (
    output oRomAddr,
    input  iRomData,
    output oX,
    output oY,
    output oColor,
    output oPlot
  );

  modport slave (
    input  oRomAddr,
    output iRomData,
    input  oX,
    input  oY,
    input  oColor,
    input  oPlot
  );

endinterface

// File: rtl/blit_delay_line.sv
// rtl/blit_delay_line.sv - DEPTH-stage shift register aligning pixel tags with ROM read data
module blit_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [WIDTH-1:0] i_tag,
  output logic [WIDTH-1:0] o_tag
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/image_blitter.sv
// rtl/image_blitter.sv - streams an IMG_W x IMG_H ROM image (or solid fill) to the pixel bus with origin and clipping.
// Optional BLIT_TRANSPARENCY_EN adds iKeyColor: ROM pixels equal to the key are not plotted.
module image_blitter import blit_pkg::*; #(
  parameter int SCREEN_W    = BLIT_SCREEN_W,
  parameter int SCREEN_H    = BLIT_SCREEN_H,
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOR_W     = BLIT_COLOR_W,
  parameter int ADDR_W      = 15,
  parameter int ROM_LATENCY = 1
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iStart,
  input  logic               iFill,
  input  logic [COLOR_W-1:0] iFillColor,
  input  logic [X_W-1:0]     iX0,
  input  logic [Y_W-1:0]     iY0,
`ifdef BLIT_TRANSPARENCY_EN
  input  logic [COLOR_W-1:0] iKeyColor,
`endif
  image_blitter_if.master    bus,
  output logic               oBusy,
  output logic               oDone
);

  localparam int                N_PIX      = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_PIX - 1);
  localparam logic [X_W-1:0]    LAST_COL   = X_W'(IMG_W - 1);
  localparam logic [X_W:0]      CLIP_X     = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0]      CLIP_Y     = (Y_W + 1)'(SCREEN_H);
  localparam int                CNT_W      = 3;
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(ROM_LATENCY - 1);
  localparam int                TAG_W      = 1 + (X_W + 1) + (Y_W + 1);

  blit_state_t r_state;
  blit_state_t w_next_state;
  logic        w_busy;
  logic        w_done;

  logic [X_W-1:0]     r_x0;
  logic [Y_W-1:0]     r_y0;
  logic               r_fill;
  logic [COLOR_W-1:0] r_fill_color;
  logic [X_W-1:0]     r_col;
  logic [Y_W-1:0]     r_row;
  logic [ADDR_W-1:0]  r_addr;
  logic [CNT_W-1:0]   r_drain_cnt;
  logic [X_W-1:0]     r_last_x;
  logic [Y_W-1:0]     r_last_y;
  logic [COLOR_W-1:0] r_last_color;

  logic [X_W:0]       w_sx;
  logic [Y_W:0]       w_sy;
  logic [TAG_W-1:0]   w_tag_in;
  logic [TAG_W-1:0]   w_tag_out;
  logic               w_out_valid;
  logic [X_W:0]       w_out_sx;
  logic [Y_W:0]       w_out_sy;
  logic               w_in_screen;
  logic               w_plot;
  logic [COLOR_W-1:0] w_live_color;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iStart) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (r_addr == LAST_ADDR) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_busy = 1'b1;
        if (r_drain_cnt == DRAIN_LAST) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Run parameters are frozen at start so the caller may retarget the inputs mid-run.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_x0         <= '0;
      r_y0         <= '0;
      r_fill       <= 1'b0;
      r_fill_color <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_addr       <= '0;
      r_drain_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (iStart) begin
            r_x0         <= iX0;
            r_y0         <= iY0;
            r_fill       <= iFill;
            r_fill_color <= iFillColor;
            r_col        <= '0;
            r_row        <= '0;
            r_addr       <= '0;
          end
        end
        ST_RUN: begin
          if (r_addr != LAST_ADDR) r_addr <= r_addr + 1'b1;
          if (r_col == LAST_COL) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
          r_drain_cnt <= '0;
        end
        ST_DRAIN: r_drain_cnt <= r_drain_cnt + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef BLIT_TRANSPARENCY_EN
  logic [COLOR_W-1:0] r_key;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset)                          r_key <= '0;
    else if (r_state == ST_IDLE && iStart) r_key <= iKeyColor;
  end

  assign w_plot = w_in_screen && (r_fill || (bus.iRomData != r_key));
`else
  assign w_plot = w_in_screen;
`endif

  // One extra bit keeps the carry so off-screen sums are clipped instead of wrapping.
  assign w_sx     = {1'b0, r_x0} + {1'b0, r_col};
  assign w_sy     = {1'b0, r_y0} + {1'b0, r_row};
  assign w_tag_in = {(r_state == ST_RUN), w_sx, w_sy};

  blit_delay_line #(
    .DEPTH (ROM_LATENCY),
    .WIDTH (TAG_W)
  ) u_delay (
    .iClock (iClock),
    .iReset (iReset),
    .i_tag  (w_tag_in),
    .o_tag  (w_tag_out)
  );

  assign {w_out_valid, w_out_sx, w_out_sy} = w_tag_out;
  assign w_in_screen  = w_out_valid && (w_out_sx < CLIP_X) && (w_out_sy < CLIP_Y);
  assign w_live_color = r_fill ? r_fill_color : bus.iRomData;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_last_x     <= '0;
      r_last_y     <= '0;
      r_last_color <= '0;
    end else if (w_plot) begin
      r_last_x     <= w_out_sx[X_W-1:0];
      r_last_y     <= w_out_sy[Y_W-1:0];
      r_last_color <= w_live_color;
    end
  end

  // The ROM word for the emerging tag arrives this cycle, so the plotted pixel bypasses the hold registers.
  assign bus.oRomAddr = r_addr;
  assign bus.oPlot    = w_plot;
  assign bus.oX       = w_plot ? w_out_sx[X_W-1:0] : r_last_x;
  assign bus.oY       = w_plot ? w_out_sy[Y_W-1:0] : r_last_y;
  assign bus.oColor   = w_plot ? w_live_color      : r_last_color;
  assign oBusy        = w_busy;
  assign oDone        = w_done;

endmodule

// File: tb/tb_image_blitter.sv
// tb/tb_image_blitter.sv - randomized self-checking bench for image_blitter against a pixel-list reference model
module tb_image_blitter;

  localparam int NI = 3;
`ifdef BLIT_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       fill;
  logic [2:0] fill_color;
  logic [2:0] key;
  logic [7:0] x0;
  logic [6:0] y0;

  logic [7:0] mx0;
  logic [6:0] my0;
  logic       mfill;
  logic [2:0] mfc;
  logic [2:0] mkey;

  logic [2:0] rom_mem [16];
  logic [2:0] rp [NI][4];

  logic [14:0]   o_addr [NI];
  logic [7:0]    o_x    [NI];
  logic [6:0]    o_y    [NI];
  logic [2:0]    o_col  [NI];
  logic [NI-1:0] o_plot;
  logic [NI-1:0] o_busy;
  logic [NI-1:0] o_done;

  logic [7:0] last_x [NI];
  logic [6:0] last_y [NI];
  logic [2:0] last_c [NI];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  image_blitter_if if_a ();
  image_blitter_if if_b ();
  image_blitter_if if_c ();

  image_blitter #(.IMG_W(4), .IMG_H(3), .ROM_LATENCY(1)) u_a (
    .iClock (clk), .iReset (rst), .iStart (start), .iFill (fill),
    .iFillColor (fill_color), .iX0 (x0), .iY0 (y0),
`ifdef BLIT_TRANSPARENCY_EN
    .iKeyColor (key),
`endif
    .bus (if_a), .oBusy (o_busy[0]), .oDone (o_done[0])
  );

  image_blitter #(.IMG_W(4), .IMG_H(3), .ROM_LATENCY(3)) u_b (
    .iClock (clk), .iReset (rst), .iStart (start), .iFill (fill),
    .iFillColor (fill_color), .iX0 (x0), .iY0 (y0),
`ifdef BLIT_TRANSPARENCY_EN
    .iKeyColor (key),
`endif
    .bus (if_b), .oBusy (o_busy[1]), .oDone (o_done[1])
  );

  image_blitter #(.IMG_W(1), .IMG_H(1), .ROM_LATENCY(2)) u_c (
    .iClock (clk), .iReset (rst), .iStart (start), .iFill (fill),
    .iFillColor (fill_color), .iX0 (x0), .iY0 (y0),
`ifdef BLIT_TRANSPARENCY_EN
    .iKeyColor (key),
`endif
    .bus (if_c), .oBusy (o_busy[2]), .oDone (o_done[2])
  );

  assign if_a.iRomData = rp[0][0];
  assign if_b.iRomData = rp[1][2];
  assign if_c.iRomData = rp[2][1];

  assign o_addr[0] = if_a.oRomAddr;  assign o_addr[1] = if_b.oRomAddr;  assign o_addr[2] = if_c.oRomAddr;
  assign o_x[0]    = if_a.oX;        assign o_x[1]    = if_b.oX;        assign o_x[2]    = if_c.oX;
  assign o_y[0]    = if_a.oY;        assign o_y[1]    = if_b.oY;        assign o_y[2]    = if_c.oY;
  assign o_col[0]  = if_a.oColor;    assign o_col[1]  = if_b.oColor;    assign o_col[2]  = if_c.oColor;
  assign o_plot[0] = if_a.oPlot;     assign o_plot[1] = if_b.oPlot;     assign o_plot[2] = if_c.oPlot;

  // Synchronous ROM: word for the address seen at an edge emerges L edges later.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      rp[i][0] <= rom_mem[o_addr[i][3:0]];
      for (int j = 1; j < 4; j++) rp[i][j] <= rp[i][j-1];
    end
  end

  function automatic int img_w(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int img_h(input int i);
    return (i == 2) ? 1 : 3;
  endfunction

  function automatic int img_lat(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 2);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycle c counts from the first RUN cycle; anything after abort_c is inside or after a reset.
  task automatic check_cycle(input int c, input int abort_c);
    for (int i = 0; i < NI; i++) begin
      int         n;
      int         k;
      int         lat;
      logic [8:0] sx;
      logic [7:0] sy;
      logic [2:0] col;
      logic       ep;
      n   = img_w(i) * img_h(i);
      lat = img_lat(i);
      k   = c - lat;
      ep  = 1'b0;
      if (abort_c >= 0 && c > abort_c) begin
        last_x[i] = '0;
        last_y[i] = '0;
        last_c[i] = '0;
        check_val($sformatf("u%0d.busy c%0d", i, c), o_busy[i], 0);
        check_val($sformatf("u%0d.done c%0d", i, c), o_done[i], 0);
        check_val($sformatf("u%0d.addr c%0d", i, c), o_addr[i], 0);
      end else begin
        if (k >= 0 && k < n) begin
          sx  = 9'(mx0 + k % img_w(i));
          sy  = 8'(my0 + k / img_w(i));
          col = mfill ? mfc : rom_mem[4'(k)];
          ep  = (sx < 160) && (sy < 120);
          if (TRANSP && !mfill && rom_mem[4'(k)] == mkey) ep = 1'b0;
          if (ep) begin
            last_x[i] = sx[7:0];
            last_y[i] = sy[6:0];
            last_c[i] = col;
          end
        end
        check_val($sformatf("u%0d.done c%0d", i, c), o_done[i], (c == n + lat) ? 1 : 0);
        check_val($sformatf("u%0d.busy c%0d", i, c), o_busy[i], (c < n + lat) ? 1 : 0);
        if (c < n) check_val($sformatf("u%0d.addr c%0d", i, c), o_addr[i], c);
      end
      check_val($sformatf("u%0d.plot c%0d", i, c), o_plot[i], ep);
      check_val($sformatf("u%0d.x c%0d", i, c), o_x[i], last_x[i]);
      check_val($sformatf("u%0d.y c%0d", i, c), o_y[i], last_y[i]);
      check_val($sformatf("u%0d.color c%0d", i, c), o_col[i], last_c[i]);
    end
  endtask

  // Entered and left at a negedge with every instance idle; pulse_c/abort_c < 0 disable those events.
  task automatic run_case(input logic [7:0] ax, input logic [6:0] ay, input logic af,
                          input logic [2:0] afc, input logic [2:0] akey,
                          input int pulse_c, input int abort_c);
    x0 = ax;  y0 = ay;  fill = af;  fill_color = afc;  key = akey;
    mx0 = ax; my0 = ay; mfill = af; mfc = afc;         mkey = akey;
    start = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      check_cycle(c, abort_c);
      rst   = (c == abort_c);
      start = (c == pulse_c);
      if (c == 2) begin
        x0         = 8'($urandom);
        y0         = 7'($urandom);
        fill       = 1'($urandom);
        fill_color = 3'($urandom);
        key        = 3'($urandom);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fill = 1'b0; fill_color = '0; key = '0; x0 = '0; y0 = '0;
    mx0 = '0; my0 = '0; mfill = 1'b0; mfc = '0; mkey = '0;
    for (int a = 0; a < 16; a++) rom_mem[a] = 3'(a);
    repeat (3) @(negedge clk);
    check_cycle(1, 0);
    rst = 1'b0;
    @(negedge clk);

    run_case(8'd0,   7'd0,   1'b0, 3'd0, 3'd0, -1, -1);
    run_case(8'd158, 7'd118, 1'b0, 3'd0, 3'd7, -1, -1);
    run_case(8'd10,  7'd20,  1'b1, 3'd5, 3'd5, -1, -1);
    run_case(8'd50,  7'd60,  1'b0, 3'd2, 3'd0,  3, -1);
    run_case(8'd1,   7'd2,   1'b0, 3'd1, 3'd4,  5,  5);
    run_case(8'd0,   7'd0,   1'b0, 3'd0, 3'd0, -1, -1);

    for (int r = 0; r < 20; r++) begin
      logic [7:0] rx;
      logic [6:0] ry;
      for (int a = 0; a < 16; a++) rom_mem[a] = 3'($urandom);
      rx = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(150, 159)) : 8'($urandom);
      ry = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(112, 119)) : 7'($urandom);
      run_case(rx, ry, 1'($urandom), 3'($urandom), 3'($urandom),
               int'($urandom_range(0, 4)) - 1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
